// File: rtl/pe_feeder.sv
// pe_feeder: walks neuron/weight SRAMs for a matrix-vector job and feeds chunk pairs to the PE.
// Optional PE_FEEDER_PERF_EN adds a 32-bit saturating busy-cycle counter on perf_cycles.
module pe_feeder #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [OUT_W-1:0]  out_num,
  input  logic [ADDR_W-1:0] neuron_base,
  input  logic [ADDR_W-1:0] weight_base,
  output logic              busy,
  output logic              done,
  output logic              nram_rd_en,
  output logic [ADDR_W-1:0] nram_addr,
  input  logic [511:0]      nram_rdata,
  output logic              wram_rd_en,
  output logic [ADDR_W-1:0] wram_addr,
  input  logic [511:0]      wram_rdata,
  output logic [511:0]      neuron,
  output logic [511:0]      weight,
  output logic [1:0]        ctl,
  output logic              vld_o
`ifdef PE_FEEDER_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, chunk_q, chunk_d;
  logic [OUT_W-1:0]  out_num_q, out_num_d, out_q, out_d;
  logic [ADDR_W-1:0] nbase_q, nbase_d, waddr_q, waddr_d;
  logic [1:0]        ctl_q, ctl_d;
  logic              vld_q, vld_d;
  logic              last_chunk, last_out;
  assign last_chunk = chunk_q == len_q - LEN_W'(1);
  assign last_out   = out_q == out_num_q - OUT_W'(1);
  // Next-state: zero-length jobs go straight to FLUSH so done/busy pulse without any reads
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    out_num_d = out_num_q;
    nbase_d   = nbase_q;
    waddr_d   = waddr_q;
    chunk_d   = chunk_q;
    out_d     = out_q;
    ctl_d     = 2'b00;
    vld_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        len_d     = len;
        out_num_d = out_num;
        nbase_d   = neuron_base;
        waddr_d   = weight_base;
        chunk_d   = '0;
        out_d     = '0;
        state_d   = (len != '0 && out_num != '0) ? RUN : FLUSH;
      end
      RUN: begin
        vld_d   = 1'b1;
        ctl_d   = {last_chunk, chunk_q == '0};
        waddr_d = waddr_q + ADDR_W'(1);
        chunk_d = last_chunk ? '0 : chunk_q + LEN_W'(1);
        out_d   = last_chunk ? out_q + OUT_W'(1) : out_q;
        state_d = (last_chunk && last_out) ? FLUSH : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and job registers; ctl/vld trail the read issue by one cycle to align with SRAM data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      out_num_q <= '0;
      nbase_q   <= '0;
      waddr_q   <= '0;
      chunk_q   <= '0;
      out_q     <= '0;
      ctl_q     <= 2'b00;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      out_num_q <= out_num_d;
      nbase_q   <= nbase_d;
      waddr_q   <= waddr_d;
      chunk_q   <= chunk_d;
      out_q     <= out_d;
      ctl_q     <= ctl_d;
      vld_q     <= vld_d;
    end
  end
  assign nram_rd_en = state_q == RUN;
  assign wram_rd_en = state_q == RUN;
  assign nram_addr  = nram_rd_en ? nbase_q + ADDR_W'(chunk_q) : '0;
  assign wram_addr  = wram_rd_en ? waddr_q : '0;
  assign busy       = state_q != IDLE;
  assign done       = state_q == FLUSH;
  assign neuron     = nram_rdata;
  assign weight     = wram_rdata;
  assign ctl        = ctl_q;
  assign vld_o      = vld_q;
`ifdef PE_FEEDER_PERF_EN
  logic [31:0] perf_q, perf_d;
  // Busy-cycle counter: cleared on accepted start, saturating, held while idle
  always_comb begin
    perf_d = (state_q == IDLE && start) ? '0 : (busy && perf_q != '1) ? perf_q + 32'd1 : perf_q;
  end
  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign perf_cycles = perf_q;
`endif
endmodule

// File: doc/pe_feeder.md
# pe_feeder

Operand sequencer that sits directly upstream of the parallel PE. On a start command it walks the neuron and weight SRAMs for a matrix-vector job of `out_num` output neurons, each reduced over `len` 512-bit chunks. It presents one neuron/weight chunk pair per cycle with the PE's `ctl`/`vld_i` sideband and pulses `done` when the last chunk has been delivered.

## Interface

Parameters:
- ADDR_W, 10, SRAM word-address width (both SRAMs).
- LEN_W, 8, width of `len` (chunks per output neuron).
- OUT_W, 8, width of `out_num`.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  chunks per output; sampled on accepted start.
- out_num  in  OUT_W  output neurons per job; sampled on accepted start.
- neuron_base  in  ADDR_W  first neuron-SRAM address; sampled on start.
- weight_base  in  ADDR_W  first weight-SRAM address; sampled on start.
- busy  out  1  high from the cycle after accepted start through the `done` cycle.
- done  out  1  one-cycle completion pulse.
- nram_rd_en  out  1  neuron SRAM read enable.
- nram_addr  out  ADDR_W  neuron SRAM address.
- nram_rdata  in  512  neuron SRAM data; valid the cycle after `nram_rd_en`.
- wram_rd_en  out  1  weight SRAM read enable.
- wram_addr  out  ADDR_W  weight SRAM address.
- wram_rdata  in  512  weight SRAM data; valid the cycle after `wram_rd_en`.
- neuron  out  512  to PE; equals `nram_rdata`; don't-care while `vld_o` is low.
- weight  out  512  to PE; equals `wram_rdata`; don't-care while `vld_o` is low.
- ctl  out  2  to PE: bit0 first chunk, bit1 last chunk (01 first, 00 middle, 10 last, 11 single).
- vld_o  out  1  to PE `vld_i`; a chunk pair is on `neuron`/`weight`.

## Operation

- FSM states: IDLE, RUN, FLUSH.
  - IDLE → RUN on `start` with `len`≠0 and `out_num`≠0. Parameters are latched and counters cleared.
  - IDLE with `start` and (`len`==0 or `out_num`==0): no reads are issued; `done` pulses the next cycle with `busy` high for that one cycle; the FSM returns to IDLE.
  - RUN: every cycle asserts both read enables.
    - `nram_addr` = `neuron_base` + chunk_idx.
    - `wram_addr` = `weight_base` + global_idx.
    - chunk_idx counts 0..len-1 and then restarts, incrementing out_idx.
    - global_idx counts 0..len·out_num−1 and never restarts.
    - Address sums are modulo 2^ADDR_W (wrap silently).
  - RUN → FLUSH after issuing the read with chunk_idx==len−1 and out_idx==out_num−1.
  - FLUSH: no reads; the last data pair is presented; `done`=1; → IDLE.
- `ctl`/`vld_o` are registered one stage behind the read issue so they align with SRAM data:
  - ctl bit0 = (chunk_idx==0) at issue.
  - ctl bit1 = (chunk_idx==len−1) at issue.
- `start` while not in IDLE is ignored.
- No backpressure: the PE consumes one pair per cycle unconditionally.

## Timing

- Reset values: `busy`=0, `done`=0, `nram_rd_en`=`wram_rd_en`=0, addresses=0, `ctl`=00, `vld_o`=0, FSM=IDLE.
- Start sampled at edge 0 → reads issued in cycles 1..len·out_num.
- `vld_o` is high in cycles 2..len·out_num+1, with no gaps.
- `done` pulses in cycle len·out_num+1, coincident with the final `vld_o` (ctl bit1=1).
- `busy` is high in cycles 1..len·out_num+1.
- A new `start` is accepted in the cycle after `done`, giving a minimum one idle cycle between jobs.
- Reset asserted mid-job: all outputs return to reset values immediately; no `done`; any partial PE sum is discarded by the PE's own reset.

## Configuration

- `PE_FEEDER_PERF_EN`
  - Defined: adds output `perf_cycles` (32 bits). It clears on accepted start, increments every cycle `busy`=1, holds its value in IDLE, resets to 0, and saturates at 0xFFFF_FFFF.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan

- Reset mid-RUN (len=8, out_num=4, rst at cycle 5) → all outputs reset in the same cycle, no `done`; a subsequent start with len=2, out_num=1 runs normally.
- len=3, out_num=2, bases 0x010/0x100:
  - nram_addr 010,011,012,010,011,012
  - wram_addr 100..105
  - ctl 01,00,10,01,00,10 in cycles 2..7
  - `done` in cycle 7, `busy` cycles 1..7
- len=1, out_num=3 → ctl=11 on three consecutive vld cycles; `done` in cycle 4.
- Wrap: ADDR_W=10, weight_base=0x3FE, len=4, out_num=1 → wram_addr 3FE,3FF,000,001.
- len=0 → no read enables ever high; `done` and `busy` pulse one cycle after start. `start` held high during a job (len=4, out_num=2) → only one job runs.
- PERF_EN build: len=5, out_num=2 → `perf_cycles`=11 after `done` and holds; the non-PERF build compiles without the port.
